// File: rtl/uart_fifo_port_pkg.sv
// Shared constants for the buffered UART port: default line rate, interrupt bit
// positions and TX feeder state encoding.
package uart_fifo_port_pkg;

    localparam int DEFAULT_BAUD = 115200;

    localparam int INT_RX  = 0;
    localparam int INT_TXE = 1;
    localparam int INT_OVR = 2;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_WAIT = 2'd1,
        TX_BUSY = 2'd2
    } feeder_state_t;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_async_receiver.sv
// 8N1 serial receiver: samples mid-bit after a start edge, pulses data_ready for one cycle
// per byte with a valid stop bit.
module uart_async_receiver
    import uart_fifo_port_pkg::*;
#(
    parameter int CLK_FREQ = 20000000,
    parameter int BAUD     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready
);
    localparam int DIV  = baud_div(CLK_FREQ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV) + 1;

    logic          rx_meta;
    logic          rx_sync;
    logic          active;
    logic [CW-1:0] cnt;
    logic [CW-1:0] target;
    logic [3:0]    nbit;
    logic [7:0]    shreg;

    assign target = (nbit == 4'd0) ? CW'(HALF - 1) : CW'(DIV - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            active   <= 1'b0;
            cnt      <= '0;
            nbit     <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rx_ready <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_ready <= 1'b0;
            if (!active) begin
                if (!rx_sync) begin
                    active <= 1'b1;
                    cnt    <= '0;
                    nbit   <= '0;
                end
            end else if (cnt == target) begin
                cnt <= '0;
                if (nbit == 4'd0) begin
                    // a start bit that is high again at mid-bit was a glitch
                    if (rx_sync) active <= 1'b0;
                    else         nbit   <= 4'd1;
                end else if (nbit <= 4'd8) begin
                    shreg <= {rx_sync, shreg[7:1]};
                    nbit  <= nbit + 4'd1;
                end else begin
                    active <= 1'b0;
                    if (rx_sync) begin
                        rx_data  <= shreg;
                        rx_ready <= 1'b1;
                    end
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_async_transmitter.sv
// 8N1 serial transmitter: one start pulse loads a byte, busy stays high until the stop bit ends.
module uart_async_transmitter
    import uart_fifo_port_pkg::*;
#(
    parameter int CLK_FREQ = 20000000,
    parameter int BAUD     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy
);
    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(DIV) + 1;

    logic [CW-1:0] cnt;
    logic [3:0]    nbit;
    logic [8:0]    shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            cnt     <= '0;
            nbit    <= '0;
            shreg   <= '0;
        end else if (!tx_busy) begin
            tx <= 1'b1;
            if (tx_start) begin
                shreg   <= {1'b1, tx_data};
                tx      <= 1'b0;
                tx_busy <= 1'b1;
                cnt     <= '0;
                nbit    <= '0;
            end
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
            // nbit 9 is the stop bit; busy drops only once it has been held a full bit time
            if (nbit == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                tx    <= shreg[0];
                shreg <= {1'b1, shreg[8:1]};
                nbit  <= nbit + 4'd1;
            end
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a separate occupancy counter.
// A pop frees a slot in the same cycle, so a simultaneous push to a full FIFO is accepted.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; stale entries are never visible because rdata is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_fifo_port.sv
// Buffered UART port: RX/TX byte FIFOs around the UART cores, a TX feeder FSM and
// rx-level / tx-empty / overrun interrupt causes with per-cause enables.
module uart_fifo_port
    import uart_fifo_port_pkg::*;
#(
    parameter int CLK_FREQ  = 20000000,
    parameter int BAUD      = DEFAULT_BAUD,
    parameter int RX_DEPTH  = 16,
    parameter int TX_DEPTH  = 16,
    parameter int RX_THRESH = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_push,
    output logic                        tx_full,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    output logic [7:0]                  rx_data,
    input  logic                        rx_pop,
    output logic                        rx_valid,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    input  logic [2:0]                  int_en,
    output logic [2:0]                  int_cause,
    output logic                        int_req,
    input  logic                        int_ack,
    output logic                        TxD,
    input  logic                        RxD
);
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;

    feeder_state_t state;
    logic [7:0]    tx_head;
    logic [7:0]    tx_byte;
    logic          tx_empty;
    logic          tx_pop;
    logic          tx_start;
    logic          tx_busy;
    logic [7:0]    rx_byte;
    logic          rx_ready;
    logic          rx_full;
    logic          rx_empty;
    logic          txe;
    logic          ovr;
    logic          txe_set;
    logic          ovr_set;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (tx_data),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_ready),
        .pop   (rx_pop),
        .wdata (rx_byte),
        .rdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    uart_async_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_byte),
        .tx       (TxD),
        .tx_busy  (tx_busy)
    );

    uart_async_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (RxD),
        .rx_data  (rx_byte),
        .rx_ready (rx_ready)
    );

    assign rx_valid = !rx_empty;
    assign tx_pop   = (state == TX_IDLE) && !tx_empty && !tx_busy;

    // Head byte is latched on the pop edge so tx_start and its data appear together next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= TX_IDLE;
            tx_start <= 1'b0;
            tx_byte  <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                TX_IDLE: if (tx_pop) begin
                    tx_start <= 1'b1;
                    tx_byte  <= tx_head;
                    state    <= TX_WAIT;
                end
                TX_WAIT: if (tx_busy)  state <= TX_BUSY;
                TX_BUSY: if (!tx_busy) state <= TX_IDLE;
                default: state <= TX_IDLE;
            endcase
        end
    end

    // A push in the same cycle keeps the count at 1, so the FIFO is not actually draining
    assign txe_set = tx_pop && (tx_count == TCW'(1)) && !tx_push;
    assign ovr_set = rx_ready && rx_full && !rx_pop;

    assign int_cause[INT_RX]  = (rx_count >= RCW'(RX_THRESH));
    assign int_cause[INT_TXE] = txe;
    assign int_cause[INT_OVR] = ovr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txe     <= 1'b0;
            ovr     <= 1'b0;
            int_req <= 1'b0;
        end else begin
            txe     <= txe_set || (txe && !int_ack);
            ovr     <= ovr_set || (ovr && !int_ack);
            int_req <= |(int_cause & int_en);
        end
    end

endmodule

// File: tb/tb_uart_fifo_port.sv
// Directed bench for uart_fifo_port: serial TX decoder and RX frame driver feed byte scoreboards.
module tb_uart_fifo_port;

    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD      = 100_000;
    localparam int DIV       = 16;
    localparam int RX_DEPTH  = 4;
    localparam int TX_DEPTH  = 4;
    localparam int RX_THRESH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_push;
    logic       tx_full;
    logic [2:0] tx_count;
    logic [7:0] rx_data;
    logic       rx_pop;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic [2:0] int_en;
    logic [2:0] int_cause;
    logic       int_req;
    logic       int_ack;
    logic       TxD;
    logic       RxD;

    int checks = 0;
    int errors = 0;
    int frames = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    uart_fifo_port #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .RX_DEPTH (RX_DEPTH),
        .TX_DEPTH (TX_DEPTH),
        .RX_THRESH(RX_THRESH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_push  (tx_push),
        .tx_full  (tx_full),
        .tx_count (tx_count),
        .rx_data  (rx_data),
        .rx_pop   (rx_pop),
        .rx_valid (rx_valid),
        .rx_count (rx_count),
        .int_en   (int_en),
        .int_cause(int_cause),
        .int_req  (int_req),
        .int_ack  (int_ack),
        .TxD      (TxD),
        .RxD      (RxD)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RxD = fr[i];
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_data = b;
        tx_push = 1'b1;
        tx_exp.push_back(b);
        @(negedge clk);
        tx_push = 1'b0;
    endtask

    task automatic rx_read(input string tag);
        logic [7:0] e;
        e = 8'h00;
        if (rx_exp.size() != 0) e = rx_exp.pop_front();
        check({tag, "_valid"}, rx_valid, 1);
        check(tag, rx_data, e);
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t;
        t = 0;
        while (frames < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("tx_frame_count", frames, n);
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
    endtask

    // Serial decoder on TxD; a frame cut short by reset is abandoned
    initial begin : tx_monitor
        logic [7:0] sh;
        logic       stop_b;
        logic       abort;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && TxD === 1'b0) begin
                abort  = 1'b0;
                sh     = '0;
                stop_b = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    repeat ((b == 0) ? DIV / 2 : DIV) begin
                        @(negedge clk);
                        if (rst) abort = 1'b1;
                    end
                    if (abort) break;
                    if (b >= 1 && b <= 8) sh[b-1] = TxD;
                    if (b == 9) stop_b = TxD;
                end
                if (!abort) begin
                    frames++;
                    check("tx_stop_bit", stop_b, 1);
                    check("tx_queue_has_entry", tx_exp.size() != 0, 1);
                    if (tx_exp.size() != 0) check("tx_byte", sh, tx_exp.pop_front());
                end
            end
        end
    end

    initial begin : stimulus
        int t;
        int base;

        rst = 1'b1; RxD = 1'b1; tx_push = 1'b0; tx_data = '0;
        rx_pop = 1'b0; int_en = '0; int_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_txd", TxD, 1);
        check("reset_tx_count", tx_count, 0);
        check("reset_tx_full", tx_full, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_count", rx_count, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_int_cause", int_cause, 0);
        check("reset_int_req", int_req, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // back-to-back TX bytes, tx-empty interrupt
        int_en = 3'b010;
        push_tx(8'h55);
        push_tx(8'hA3);
        push_tx(8'h0F);
        wait_frames(3, 800);
        check("t1_tx_count", tx_count, 0);
        check("t1_int_cause", int_cause, 3'b010);
        check("t1_int_req", int_req, 1);
        repeat (40) @(negedge clk);
        check("t1_no_extra_frames", frames, 3);

        // ack in the same cycle as a new tx-empty event: set wins
        tx_data = 8'h5A; tx_push = 1'b1; tx_exp.push_back(8'h5A);
        @(negedge clk);
        tx_push = 1'b0; int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        check("t6_txe_kept", int_cause[1], 1);
        check("t6_int_req", int_req, 1);
        @(negedge clk);
        check("t6_int_req_later", int_req, 1);
        wait_frames(4, 300);
        pulse_ack();
        check("t6_txe_cleared", int_cause[1], 0);
        @(negedge clk);
        check("t6_int_req_dropped", int_req, 0);

        // RX threshold interrupt
        int_en = 3'b001;
        send_rx(8'h11); rx_exp.push_back(8'h11);
        check("t2_count1", rx_count, 1);
        check("t2_rx_below", int_cause[0], 0);
        send_rx(8'h22); rx_exp.push_back(8'h22);
        check("t2_count2", rx_count, 2);
        check("t2_rx_at_thresh", int_cause[0], 1);
        send_rx(8'h33); rx_exp.push_back(8'h33);
        check("t2_count3", rx_count, 3);
        check("t2_int_req", int_req, 1);
        rx_read("t2_rx_11");
        rx_read("t2_rx_22");
        check("t2_count_after", rx_count, 1);
        check("t2_rx_cleared", int_cause[0], 0);
        check("t2_int_req_held", int_req, 1);
        @(negedge clk);
        check("t2_int_req_fell", int_req, 0);
        rx_read("t2_rx_33");
        check("t2_empty", rx_valid, 0);

        // RX overrun on a full FIFO
        int_en = 3'b100;
        for (int i = 1; i <= 4; i++) begin
            send_rx(8'hC0 + 8'(i));
            rx_exp.push_back(8'hC0 + 8'(i));
        end
        check("t3_full_count", rx_count, 4);
        send_rx(8'hC5);
        check("t3_ovr_set", int_cause[2], 1);
        check("t3_count_held", rx_count, 4);
        @(negedge clk);
        check("t3_int_req", int_req, 1);
        pulse_ack();
        check("t3_ovr_cleared", int_cause[2], 0);

        // pop coincident with receiver data_ready on a full FIFO
        fork
            send_rx(8'h99);
        join_none
        t = 0;
        while (dut.rx_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("t4_ready_seen", dut.rx_ready, 1);
        check("t4_head", rx_data, rx_exp.pop_front());
        rx_exp.push_back(8'h99);
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
        check("t4_count", rx_count, 4);
        check("t4_no_ovr", int_cause[2], 0);
        repeat (20) @(negedge clk);
        rx_read("t4_rx_c2");
        rx_read("t4_rx_c3");
        rx_read("t4_rx_c4");
        rx_read("t4_rx_99");
        check("t4_drained", rx_count, 0);

        // reset in the middle of a TX frame with bytes still queued
        int_en = 3'b000;
        push_tx(8'hA1);
        push_tx(8'hA2);
        push_tx(8'hA3);
        push_tx(8'hA4);
        repeat (60) @(negedge clk);
        check("t5_queued", tx_count, 3);
        rst = 1'b1;
        #1;
        check("t5_txd_high", TxD, 1);
        check("t5_tx_count", tx_count, 0);
        check("t5_tx_full", tx_full, 0);
        check("t5_rx_valid", rx_valid, 0);
        check("t5_rx_data", rx_data, 0);
        check("t5_int_cause", int_cause, 0);
        check("t5_int_req", int_req, 0);
        tx_exp.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = frames;
        @(negedge clk);
        push_tx(8'h3C);
        wait_frames(base + 1, 300);
        repeat (20) @(negedge clk);
        check("t5_no_stale_frames", frames, base + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
